// File: rtl/pkt134_gmii_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | pkt134_gmii_tx                                                           |
// | Store-and-forward 134b packet words -> GMII TX (preamble, pad, FCS, IFG) |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pkt134_gmii_tx #(
    parameter int FIFO_AW       = 7,
    parameter int MAX_PKT_WORDS = 96,
    parameter int MIN_FRAME_B   = 60,
    parameter int IFG_CYCLES    = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pktData_valid,
    input  logic [133:0] pktData,
    output logic [7:0]   gmii_txd,
    output logic         gmii_tx_en,
    output logic         gmii_tx_er,
    output logic [15:0]  drop_cnt,
    output logic [15:0]  tx_pkt_cnt
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PW    = FIFO_AW + 1;
    localparam int WCW   = $clog2(MAX_PKT_WORDS + 1);
    localparam int CW    = (IFG_CYCLES > 16) ? $clog2(IFG_CYCLES) : 4;

    typedef enum logic [1:0] {W_WAIT_HEAD, W_IN_PKT, W_DROP} wstate_t;
    typedef enum logic [2:0] {R_IDLE, R_PRE, R_SFD, R_DATA, R_PAD, R_FCS, R_IFG} rstate_t;

    // Stored word: {tail, valid-1, data}; the head flag is not needed downstream.
    logic [132:0]   r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr, r_cm_ptr, r_rd_ptr, r_pkt_cnt;
    logic [PW-1:0]  w_wr_ptr_n, w_cm_ptr_n, w_waddr;
    wstate_t        r_wstate, w_wstate_n;
    logic [WCW-1:0] r_wcnt, w_wcnt_n;
    logic           w_we, w_commit, w_is_head, w_is_tail, w_room;
    logic [1:0]     w_drop_inc;
    logic [PW:0]    w_free;
    logic [16:0]    w_drop_sum;

    rstate_t        r_rstate, w_rstate_n;
    logic [CW-1:0]  r_cnt, w_cnt_n;
    logic [31:0]    r_crc, w_crc_n, w_fcs;
    logic [15:0]    r_bytes, w_bytes_n, r_drop_cnt, r_tx_pkt_cnt;
    logic [7:0]     r_txd, w_txd_n, w_rbyte;
    logic           r_tx_en, w_tx_en_n, w_rd_adv, w_done;
    logic [132:0]   w_rword;
    logic [127:0]   w_rdata;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++)
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    assign w_is_head = pktData[132];
    assign w_is_tail = pktData[133];
    // Free space is judged against committed data only: a new head discards any speculative words.
    assign w_free    = (PW + 1)'(DEPTH) - {1'b0, r_cm_ptr - r_rd_ptr};
    assign w_room    = w_free >= (PW + 1)'(MAX_PKT_WORDS);

    always_comb begin
        w_wstate_n = r_wstate;
        w_wr_ptr_n = r_wr_ptr;
        w_cm_ptr_n = r_cm_ptr;
        w_wcnt_n   = r_wcnt;
        w_waddr    = r_wr_ptr;
        w_we       = 1'b0;
        w_commit   = 1'b0;
        w_drop_inc = 2'd0;
        if (pktData_valid) begin
            if (w_is_head) begin
                if (r_wstate == W_IN_PKT)
                    w_drop_inc = 2'd1;
                w_wr_ptr_n = r_cm_ptr;
                if (!w_room) begin
                    w_drop_inc = w_drop_inc + 2'd1;
                    w_wstate_n = w_is_tail ? W_WAIT_HEAD : W_DROP;
                end else begin
                    w_we       = 1'b1;
                    w_waddr    = r_cm_ptr;
                    w_wr_ptr_n = r_cm_ptr + 1'b1;
                    w_wcnt_n   = WCW'(1);
                    if (w_is_tail) begin
                        w_cm_ptr_n = r_cm_ptr + 1'b1;
                        w_commit   = 1'b1;
                        w_wstate_n = W_WAIT_HEAD;
                    end else begin
                        w_wstate_n = W_IN_PKT;
                    end
                end
            end else if (r_wstate == W_IN_PKT) begin
                if (r_wcnt == WCW'(MAX_PKT_WORDS)) begin
                    w_wr_ptr_n = r_cm_ptr;
                    w_drop_inc = 2'd1;
                    w_wstate_n = W_DROP;
                end else begin
                    w_we       = 1'b1;
                    w_wr_ptr_n = r_wr_ptr + 1'b1;
                    w_wcnt_n   = r_wcnt + 1'b1;
                    if (w_is_tail) begin
                        w_cm_ptr_n = r_wr_ptr + 1'b1;
                        w_commit   = 1'b1;
                        w_wstate_n = W_WAIT_HEAD;
                    end
                end
            end else if (r_wstate == W_DROP && w_is_tail) begin
                w_wstate_n = W_WAIT_HEAD;
            end
        end
    end

    assign w_rword = r_mem[r_rd_ptr[FIFO_AW-1:0]];
    assign w_rdata = w_rword[127:0];
    assign w_rbyte = w_rdata[{~r_cnt[3:0], 3'b000} +: 8];
    assign w_fcs   = ~r_crc;

    // Outputs are registered from the current state, so each state's byte appears one edge later.
    always_comb begin
        w_rstate_n = r_rstate;
        w_cnt_n    = r_cnt;
        w_crc_n    = r_crc;
        w_bytes_n  = r_bytes;
        w_txd_n    = 8'h00;
        w_tx_en_n  = 1'b0;
        w_rd_adv   = 1'b0;
        w_done     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (r_pkt_cnt != '0) begin
                    w_rstate_n = R_PRE;
                    w_cnt_n    = '0;
                end
            end
            R_PRE: begin
                w_tx_en_n = 1'b1;
                w_txd_n   = 8'h55;
                w_cnt_n   = r_cnt + 1'b1;
                if (r_cnt == CW'(6)) begin
                    w_rstate_n = R_SFD;
                    w_cnt_n    = '0;
                end
            end
            R_SFD: begin
                w_tx_en_n  = 1'b1;
                w_txd_n    = 8'hD5;
                w_crc_n    = 32'hFFFFFFFF;
                w_bytes_n  = '0;
                w_cnt_n    = '0;
                w_rstate_n = R_DATA;
            end
            R_DATA: begin
                w_tx_en_n = 1'b1;
                w_txd_n   = w_rbyte;
                w_crc_n   = crc_byte(r_crc, w_rbyte);
                w_bytes_n = r_bytes + 16'd1;
                w_cnt_n   = r_cnt + 1'b1;
                if (w_rword[132] && r_cnt[3:0] == w_rword[131:128]) begin
                    w_rd_adv   = 1'b1;
                    w_cnt_n    = '0;
                    w_rstate_n = (w_bytes_n < 16'(MIN_FRAME_B)) ? R_PAD : R_FCS;
                end else if (r_cnt[3:0] == 4'hF) begin
                    w_rd_adv = 1'b1;
                    w_cnt_n  = '0;
                end
            end
            R_PAD: begin
                w_tx_en_n = 1'b1;
                w_crc_n   = crc_byte(r_crc, 8'h00);
                w_bytes_n = r_bytes + 16'd1;
                if (w_bytes_n >= 16'(MIN_FRAME_B)) begin
                    w_rstate_n = R_FCS;
                    w_cnt_n    = '0;
                end
            end
            R_FCS: begin
                w_tx_en_n = 1'b1;
                w_txd_n   = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
                w_cnt_n   = r_cnt + 1'b1;
                if (r_cnt == CW'(3)) begin
                    w_rstate_n = R_IFG;
                    w_cnt_n    = '0;
                    w_done     = 1'b1;
                end
            end
            R_IFG: begin
                w_cnt_n = r_cnt + 1'b1;
                if (r_cnt == CW'(IFG_CYCLES - 1))
                    w_rstate_n = R_IDLE;
            end
            default: w_rstate_n = R_IDLE;
        endcase
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + {15'd0, w_drop_inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate     <= W_WAIT_HEAD;
            r_wr_ptr     <= '0;
            r_cm_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_wcnt       <= '0;
            r_pkt_cnt    <= '0;
            r_rstate     <= R_IDLE;
            r_cnt        <= '0;
            r_crc        <= '0;
            r_bytes      <= '0;
            r_txd        <= '0;
            r_tx_en      <= 1'b0;
            r_drop_cnt   <= '0;
            r_tx_pkt_cnt <= '0;
        end else begin
            r_wstate   <= w_wstate_n;
            r_wr_ptr   <= w_wr_ptr_n;
            r_cm_ptr   <= w_cm_ptr_n;
            r_wcnt     <= w_wcnt_n;
            r_rd_ptr   <= r_rd_ptr + PW'(w_rd_adv);
            r_rstate   <= w_rstate_n;
            r_cnt      <= w_cnt_n;
            r_crc      <= w_crc_n;
            r_bytes    <= w_bytes_n;
            r_txd      <= w_txd_n;
            r_tx_en    <= w_tx_en_n;
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            r_tx_pkt_cnt <= r_tx_pkt_cnt + {15'd0, w_done};
            case ({w_commit, w_done})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + 1'b1;
                2'b01:   r_pkt_cnt <= r_pkt_cnt - 1'b1;
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr[FIFO_AW-1:0]] <= {w_is_tail, pktData[131:0]};
    end

    assign gmii_txd   = r_txd;
    assign gmii_tx_en = r_tx_en;
    assign gmii_tx_er = 1'b0;
    assign drop_cnt   = r_drop_cnt;
    assign tx_pkt_cnt = r_tx_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pkt134_gmii_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_pkt134_gmii_tx                                                        |
// | Randomized frame-level bench for pkt134_gmii_tx with a byte-stream model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pkt134_gmii_tx;
    localparam int IFG  = 12;
    localparam int MINB = 60;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pktData_valid;
    logic [133:0] pktData;
    logic [7:0]   gmii_txd;
    logic         gmii_tx_en, gmii_tx_er;
    logic [15:0]  drop_cnt, tx_pkt_cnt;

    always #4 clk = ~clk;

    pkt134_gmii_tx dut (
        .clk(clk), .rst(rst), .pktData_valid(pktData_valid), .pktData(pktData),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .drop_cnt(drop_cnt), .tx_pkt_cnt(tx_pkt_cnt)
    );

    int n_checks = 0, n_pass = 0;
    logic [7:0] exp_bytes[$];
    int exp_len[$];
    int out_words[$];
    int mdl_drop = 0, mdl_tx = 0, last_len = 0;
    int run_len = 0, idle_len = 100, cur_len = 0;
    logic [7:0] mon_exp;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] model_fcs(input logic [7:0] b[$]);
        logic [31:0] c;
        bit fb;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    function automatic int sum_out();
        int s;
        s = 0;
        foreach (out_words[i]) s += out_words[i];
        return s;
    endfunction

    // Expected wire image of one frame: preamble, SFD, data, zero pad, FCS LSB first.
    task automatic build_frame(input logic [7:0] d[$], input int nw);
        logic [7:0] body[$];
        logic [31:0] f;
        body = d;
        while (body.size() < MINB) body.push_back(8'h00);
        f = model_fcs(body);
        repeat (7) exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'hD5);
        foreach (body[i]) exp_bytes.push_back(body[i]);
        for (int k = 0; k < 4; k++) exp_bytes.push_back(f[8*k +: 8]);
        last_len = 8 + body.size() + 4;
        exp_len.push_back(last_len);
        out_words.push_back(nw);
        mdl_tx++;
    endtask

    task automatic drive_word(input logic [1:0] tag, input logic [3:0] vld, input logic [127:0] wd);
        pktData_valid = 1'b1;
        pktData = {tag, vld, wd};
        @(posedge clk); #1;
        pktData_valid = 1'b0;
        pktData = '0;
    endtask

    task automatic send_pkt(input int len, input int trunc, input bit expect_frame,
                            input bit fill_ab, input bit gaps);
        logic [7:0] d[$];
        logic [127:0] wd;
        logic [1:0] tag;
        logic [3:0] vld;
        int nw, nsend;
        d = {};
        for (int i = 0; i < len; i++) d.push_back(fill_ab ? 8'hAB : 8'($urandom));
        nw = (len + 15) / 16;
        nsend = (trunc > 0) ? trunc : nw;
        if (expect_frame) build_frame(d, nw);
        for (int w = 0; w < nsend; w++) begin
            wd = '0;
            for (int i = 0; i < 16; i++) begin
                if (w * 16 + i < len) wd[127 - 8*i -: 8] = d[w * 16 + i];
                else                  wd[127 - 8*i -: 8] = 8'($urandom);
            end
            tag = {(trunc == 0) && (w == nw - 1), w == 0};
            vld = tag[1] ? 4'(len - 1 - 16 * w) : 4'($urandom);
            drive_word(tag, vld, wd);
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_bytes.size() > 0 || run_len != 0) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check(t < 20000, {name, "_drain_timeout"}, t, 20000);
        repeat (20) @(negedge clk);
        check(drop_cnt == 16'(mdl_drop), {name, "_drop_cnt"}, drop_cnt, mdl_drop);
        check(tx_pkt_cnt == 16'(mdl_tx), {name, "_tx_pkt_cnt"}, tx_pkt_cnt, mdl_tx);
        @(posedge clk); #1;
    endtask

    // Byte-stream compare: every tx_en cycle against the model, idle cycles for txd=0 and IFG.
    always @(negedge clk) begin
        if (rst) begin
            run_len  = 0;
            idle_len = 100;
            cur_len  = 0;
        end else if (gmii_tx_en) begin
            if (run_len == 0) begin
                check(idle_len >= IFG, "ifg_gap", idle_len, IFG);
                check(gmii_tx_er == 1'b0, "tx_er", gmii_tx_er, 0);
                if (exp_len.size() > 0) cur_len = exp_len.pop_front();
                else begin
                    check(1'b0, "unexpected_frame", 1, 0);
                    cur_len = -1;
                end
            end
            if (exp_bytes.size() > 0) begin
                mon_exp = exp_bytes.pop_front();
                check(gmii_txd == mon_exp, "tx_byte", gmii_txd, mon_exp);
            end else begin
                check(1'b0, "tx_byte_extra", gmii_txd, 0);
            end
            run_len++;
            idle_len = 0;
        end else begin
            if (run_len != 0) begin
                check(run_len == cur_len, "frame_len", run_len, cur_len);
                if (out_words.size() > 0) void'(out_words.pop_front());
            end
            run_len = 0;
            idle_len++;
            check(gmii_txd == 8'h00, "idle_txd", gmii_txd, 0);
        end
    end

    initial begin
        #700000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] s[$];
        int k, t, kind, len;
        pktData_valid = 1'b0;
        pktData = '0;
        repeat (3) @(negedge clk);
        check(gmii_tx_en == 1'b0, "rst_tx_en", gmii_tx_en, 0);
        check(gmii_txd == 8'h00, "rst_txd", gmii_txd, 0);
        check(drop_cnt == 16'h0, "rst_drop_cnt", drop_cnt, 0);
        check(tx_pkt_cnt == 16'h0, "rst_tx_pkt_cnt", tx_pkt_cnt, 0);
        rst = 1'b0;

        s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check(model_fcs(s) == 32'hCBF43926, "model_crc_pin", model_fcs(s), 32'hCBF43926);

        repeat (5) @(posedge clk); #1;

        // 64 B packet, start latency two edges after the tail
        send_pkt(64, 0, 1, 0, 0);
        check(last_len == 76, "t1_model_len", last_len, 76);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!gmii_tx_en && k < 10);
        check(k == 3, "t1_start_latency", k, 3);
        drain("t1");

        // 20 B padded, then a single-word 0xAB packet
        send_pkt(20, 0, 1, 0, 1);
        check(last_len == 72, "t2_model_len", last_len, 72);
        send_pkt(1, 0, 1, 1, 0);
        check(last_len == 72, "t6_model_len", last_len, 72);
        drain("t2_t6");

        // Packet A aborted after two words by head of B
        send_pkt(100, 2, 0, 0, 0);
        mdl_drop++;
        send_pkt(40, 0, 1, 0, 0);
        drain("t3");

        // Two back-to-back 1514 B packets: the second finds no room
        send_pkt(1514, 0, 1, 0, 0);
        send_pkt(1514, 0, 0, 0, 0);
        mdl_drop++;
        drain("t4");

        // Oversize packet (98 words) is dropped, next packet still flows
        send_pkt(98 * 16, 0, 0, 0, 0);
        mdl_drop++;
        send_pkt(33, 0, 1, 0, 1);
        drain("oversize");

        for (int it = 0; it < 40; it++) begin
            t = 0;
            while (sum_out() > 32 && t < 20000) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk); #1;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                send_pkt($urandom_range(33, 200), $urandom_range(1, 2), 0, 0, 1);
                mdl_drop++;
            end else if (kind == 1) begin
                drive_word(2'b00, 4'h3, {4{32'($urandom)}});
                drive_word(2'b10, 4'h5, {4{32'($urandom)}});
            end
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(301, 500) : $urandom_range(1, 300);
            send_pkt(len, 0, 1, 0, 1);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
        drain("random");

        // Reset in the middle of data byte 30
        send_pkt(100, 0, 1, 0, 0);
        t = 0;
        while (run_len != 39 && t < 2000) begin
            @(negedge clk); #1;
            t++;
        end
        check(run_len == 39, "t5_reached_byte30", run_len, 39);
        rst = 1'b1;
        #1;
        check(gmii_tx_en == 1'b0, "t5_tx_en_drop", gmii_tx_en, 0);
        check(gmii_txd == 8'h00, "t5_txd_zero", gmii_txd, 0);
        exp_bytes.delete();
        exp_len.delete();
        out_words.delete();
        mdl_drop = 0;
        mdl_tx = 0;
        repeat (3) @(negedge clk);
        check(tx_pkt_cnt == 16'h0, "t5_rst_tx_pkt_cnt", tx_pkt_cnt, 0);
        #1;
        rst = 1'b0;
        repeat (200) @(negedge clk);
        drain("t5_quiet");
        send_pkt(70, 0, 1, 0, 0);
        drain("t5_after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
